// File: rtl/mdu_iterative.sv
// Iterative RV32M/RV64M multiply/divide unit for the EX stage.
// Radix-2 shift-add multiply and restoring divide on a shared 2*XLEN+1 accumulator.
module mdu_iterative #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [6:0]      op,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            is_mext,
    output logic            stall_req,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIN,
        S_DONE
    } state_t;

    localparam logic [6:0]       OP_REG   = 7'b0110011;
    localparam logic [6:0]       F7_MEXT  = 7'b0000001;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*XLEN:0]     acc_q, acc_d;
    logic [XLEN-1:0]     opnd_q, opnd_d;
    logic [2:0]          f3_q, f3_d;
    logic                sa_q, sa_d;
    logic                sb_q, sb_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                accept;
    logic                a_signed, b_signed;
    logic                sgn_a, sgn_b;
    logic [XLEN-1:0]     mag_a, mag_b;
    logic                div_zero, div_ovf;

    logic [XLEN:0]       mul_sum;
    logic [2*XLEN:0]     mul_next;
    logic [2*XLEN:0]     div_shift;
    logic [XLEN:0]       div_trial;
    logic [2*XLEN:0]     div_next;

    logic [2*XLEN-1:0]   prod, prod_s;
    logic [XLEN-1:0]     quot_s, rem_s;
    logic [XLEN-1:0]     fin_result;

    assign is_mext   = (op == OP_REG) && (funct7 == F7_MEXT);
    assign accept    = start && is_mext && (state_q == S_IDLE) && !flush;
    assign stall_req = (start && is_mext && (state_q == S_IDLE))
                     || (state_q == S_CALC) || (state_q == S_FIN);

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

    // Operand decode: MULH, MULHSU (rs1 only), DIV and REM treat operands as signed.
    always_comb begin
        a_signed = (funct3 == 3'b001) || (funct3 == 3'b010)
                || (funct3 == 3'b100) || (funct3 == 3'b110);
        b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        sgn_a    = a_signed && rs1[XLEN-1];
        sgn_b    = b_signed && rs2[XLEN-1];
        mag_a    = sgn_a ? -rs1 : rs1;
        mag_b    = sgn_b ? -rs2 : rs2;
        div_zero = funct3[2] && (rs2 == '0);
        div_ovf  = funct3[2] && !funct3[0] && (rs1 == MOST_NEG) && (rs2 == '1);
    end

    // One radix-2 step of each algorithm; the divide remainder never needs bit 2*XLEN.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
        mul_next  = acc_q[0] ? {1'b0, mul_sum, acc_q[XLEN-1:1]}
                             : {1'b0, acc_q[2*XLEN:1]};
        div_shift = {acc_q[2*XLEN-1:0], 1'b0};
        div_trial = div_shift[2*XLEN:XLEN] - {1'b0, opnd_q};
        div_next  = div_trial[XLEN] ? div_shift
                                    : {div_trial, div_shift[XLEN-1:1], 1'b1};
    end

    always_comb begin
        prod   = acc_q[2*XLEN-1:0];
        prod_s = (sa_q ^ sb_q) ? -prod : prod;
        quot_s = (sa_q ^ sb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_s  = sa_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        case (f3_q[2:1])
            2'b00:   fin_result = f3_q[0] ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
            2'b01:   fin_result = prod_s[2*XLEN-1:XLEN];
            2'b10:   fin_result = quot_s;
            default: fin_result = rem_s;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        f3_d     = f3_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        result_d = result_q;
        done_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    f3_d  = funct3;
                    sa_d  = sgn_a;
                    sb_d  = sgn_b;
                    cnt_d = '0;
                    if (div_zero) begin
                        result_d = funct3[1] ? rs1 : '1;
                        done_d   = 1'b1;
                        state_d  = S_DONE;
                    end else if (div_ovf) begin
                        result_d = funct3[1] ? '0 : rs1;
                        done_d   = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        state_d = S_CALC;
                        if (funct3[2]) begin
                            acc_d  = {{(XLEN+1){1'b0}}, mag_a};
                            opnd_d = mag_b;
                        end else begin
                            acc_d  = {{(XLEN+1){1'b0}}, mag_b};
                            opnd_d = mag_a;
                        end
                    end
                end
            end
            S_CALC: begin
                acc_d = f3_q[2] ? div_next : mul_next;
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                result_d = fin_result;
                done_d   = 1'b1;
                state_d  = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (flush && (state_q != S_IDLE)) begin
            state_d  = S_IDLE;
            done_d   = 1'b0;
            result_d = result_q;
        end

        busy_d = (state_d == S_CALC) || (state_d == S_FIN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            f3_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            f3_q     <= f3_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_mdu_iterative.sv
// Directed-vector bench for mdu_iterative (XLEN=32) with hand-computed results and latencies.
module tb_mdu_iterative;

    localparam int unsigned XLEN = 32;
    localparam logic [6:0]  OP_R = 7'b0110011;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [6:0]      op;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            flush;
    logic            is_mext;
    logic            stall_req;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mdu_iterative #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .funct3    (funct3),
        .funct7    (funct7),
        .rs1       (rs1),
        .rs2       (rs2),
        .flush     (flush),
        .is_mext   (is_mext),
        .stall_req (stall_req),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start  = 1'b1;
        op     = OP_R;
        funct7 = 7'h01;
        funct3 = f3;
        rs1    = a;
        rs2    = b;
    endtask

    // Issues one op, waits (bounded) for done, checks result, latency and stall/busy cycle counts.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input int exp_lat, input bit inject);
        int lat;
        int n_stall;
        int n_busy;
        lat = 0;
        n_stall = 0;
        n_busy = 0;
        issue(f3, a, b);
        #1 check({tag, " stall@start"}, 64'(stall_req), 64'd1);
        @(posedge clk);
        #1 start = 1'b0;
        while (!done && lat < 100) begin
            n_stall += int'(stall_req);
            n_busy  += int'(busy);
            if (inject && lat == 5) begin
                start  = 1'b1;
                funct3 = 3'b000;
                rs1    = 32'h3;
                rs2    = 32'h5;
            end
            if (lat == 8) start = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " result"}, 64'(result), 64'(exp_res));
        check({tag, " stall cycles"}, 64'(n_stall), 64'(exp_lat));
        check({tag, " busy cycles"}, 64'(n_busy), 64'(exp_lat));
        check({tag, " stall@done"}, 64'(stall_req), 64'd0);
        check({tag, " busy@done"}, 64'(busy), 64'd0);
        @(posedge clk);
        #1 check({tag, " done pulse width"}, 64'(done), 64'd0);
    endtask

    initial begin
        bit saw_done;
        reset  = 1'b1;
        start  = 1'b0;
        flush  = 1'b0;
        op     = '0;
        funct3 = '0;
        funct7 = '0;
        rs1    = '0;
        rs2    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset result", 64'(result), 64'd0);
        check("reset stall", 64'(stall_req), 64'd0);
        @(negedge clk) reset = 1'b0;

        run_op("MUL 7*-3",        3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 1'b0);
        run_op("MUL 2^16*2^16",   3'b000, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 33, 1'b0);
        run_op("MULHU 2^16*2^16", 3'b011, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 33, 1'b0);
        run_op("MULH min*min",    3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 1'b0);
        run_op("MULH -1*1",       3'b001, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 33, 1'b0);
        run_op("MULH -1*-1",      3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, 1'b0);
        run_op("MULHU max*max",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1'b0);
        run_op("MULHSU -1*2",     3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33, 1'b0);
        run_op("MULHSU 2*max",    3'b010, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0001, 33, 1'b0);
        run_op("REMU 100/7",      3'b111, 32'd100,       32'd7,         32'd2,         33, 1'b0);
        run_op("DIV -7/2",        3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33, 1'b0);
        run_op("REM -7/2",        3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33, 1'b0);
        run_op("DIV 7/-2",        3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 1'b0);
        run_op("REM 7/-2",        3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 33, 1'b0);
        run_op("DIVU max/1",      3'b101, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 33, 1'b0);
        run_op("DIVU min/max",    3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33, 1'b0);
        run_op("DIV 5/0",         3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 0,  1'b0);
        run_op("REM 5/0",         3'b110, 32'd5,         32'd0,         32'd5,         0,  1'b0);
        run_op("DIVU 5/0",        3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 0,  1'b0);
        run_op("REMU 5/0",        3'b111, 32'd5,         32'd0,         32'd5,         0,  1'b0);
        run_op("DIV ovf",         3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0,  1'b0);
        run_op("REM ovf",         3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0,  1'b0);
        run_op("DIVU 100/7 +start while busy", 3'b101, 32'd100, 32'd7, 32'd14, 33, 1'b1);

        // Non-M instruction (SUB) must not be decoded or accepted.
        @(negedge clk);
        start  = 1'b1;
        op     = OP_R;
        funct7 = 7'b0100000;
        funct3 = 3'b000;
        #1;
        check("SUB is_mext", 64'(is_mext), 64'd0);
        check("SUB stall", 64'(stall_req), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        check("SUB busy", 64'(busy), 64'd0);
        check("SUB done", 64'(done), 64'd0);
        start = 1'b0;

        // Start coinciding with flush in IDLE is not accepted.
        issue(3'b000, 32'd3, 32'd4);
        flush = 1'b1;
        @(posedge clk);
        #1 check("flush+start busy", 64'(busy), 64'd0);
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;

        // Flush at iteration 10 of a MUL.
        issue(3'b000, 32'd3, 32'd4);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk) flush = 1'b1;
        @(posedge clk);
        #1;
        check("flush busy", 64'(busy), 64'd0);
        check("flush done", 64'(done), 64'd0);
        check("flush stall", 64'(stall_req), 64'd0);
        check("flush result held", 64'(result), 64'd14);
        @(negedge clk) flush = 1'b0;
        saw_done = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1 if (done) saw_done = 1'b1;
        end
        check("flush no late done", 64'(saw_done), 64'd0);
        check("flush result still held", 64'(result), 64'd14);
        run_op("MUL 3*4 after flush", 3'b000, 32'd3, 32'd4, 32'd12, 33, 1'b0);

        // Reset in the middle of CALC.
        issue(3'b000, 32'h0000_1234, 32'd5);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        check("midreset busy", 64'(busy), 64'd0);
        check("midreset done", 64'(done), 64'd0);
        check("midreset result", 64'(result), 64'd0);
        check("midreset stall", 64'(stall_req), 64'd0);
        @(negedge clk) reset = 1'b0;
        run_op("REMU 5/7 after reset", 3'b111, 32'd5, 32'd7, 32'd5, 33, 1'b0);
        run_op("MUL 0x1234*5",         3'b000, 32'h0000_1234, 32'd5, 32'h0000_5B04, 33, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_iterative.md
Name: mdu_iterative

Overview:
- Parametrised RV32M/RV64M multiply/divide unit for the EX stage of the pipelined core.
- Decodes M-extension encodings (opcode 0110011, funct7 0000001) alongside the base ALU decoder.
- Executes MUL/MULH/MULHSU/MULHU by radix-2 shift-add and DIV/DIVU/REM/REMU by radix-2 restoring division.
- Raises a stall request while iterating and returns one registered result with a single-cycle done pulse.

Parameters:
- XLEN, 32, operand/result width (32 or 64).
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived, do not override).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  EX-stage instruction valid.
- op  input  7  instruction opcode.
- funct3  input  3  instruction funct3.
- funct7  input  7  instruction funct7.
- rs1  input  XLEN  operand A (dividend / multiplicand).
- rs2  input  XLEN  operand B (divisor / multiplier).
- flush  input  1  synchronous abort of the in-flight operation.
- is_mext  output  1  combinational: op==0110011 && funct7==0000001.
- stall_req  output  1  combinational stall to IF/ID/EX.
- busy  output  1  registered; high in CALC and FIN.
- done  output  1  registered; one-cycle result-valid pulse.
- result  output  XLEN  registered result; holds its value until the next completion.

Behaviour:
- Clock and reset: one clock domain; reset is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, result=0, counter=0. Reset has priority over flush and start, including mid-operation.
- States: IDLE, CALC, FIN, DONE.
- Accept condition: start && is_mext && state==IDLE, sampled on acceptance edge E0.
  - start with is_mext=0 is ignored.
  - start in any state other than IDLE is ignored; the pipeline is stalled then.
- At E0 the unit latches funct3, the operand signs and the magnitudes |rs1|, |rs2|.
  - A magnitude is taken only when the operand is signed for that op: MULH both operands; MULHSU rs1 only; DIV/REM both operands.
  - Counter is set to 0. Next state is CALC, except the division special cases below.
- CALC: one iteration per edge on a 2*XLEN accumulator.
  - Multiply: if multiplier LSB=1, add the multiplicand into the high half; then shift right.
  - Divide: shift the remainder left by one, trial-subtract the divisor; if non-negative, keep the difference and set the quotient bit.
  - Edges E1..E_XLEN perform the XLEN iterations; the edge with counter==XLEN-1 moves to FIN.
- FIN: applies sign correction by two's-complement negation.
  - Product: negated when the operand signs differ (MULHSU uses rs1 sign only).
  - Quotient: negated when the signs differ.
  - Remainder: takes the sign of the dividend.
  - Selects the low word (MUL), high word (MULH*), quotient or remainder into result; sets done=1; next state DONE.
- DONE: done=1 for exactly this cycle, busy=0. The next edge returns to IDLE and clears done.
- Latency: done is high in the cycle after edge E_{XLEN+1}. For XLEN=32 that is 33 edges after E0.
- Special cases, resolved at E0 (result written at E0, state→DONE, done in the cycle after E0):
  - Divide by zero: DIV/DIVU give all-ones; REM/REMU give rs1.
  - Signed overflow (rs1 = most-negative value, rs2 = -1): DIV gives rs1; REM gives 0.
- stall_req = (start && is_mext && state==IDLE) || state==CALC || state==FIN. It is 0 in DONE, so the instruction advances with result valid.
- Flush: in CALC/FIN/DONE, the next state is IDLE, done is not asserted and result is unchanged. start is not accepted on the flush edge.
- Width rules: internal accumulator is 2*XLEN+1 bits; negation uses modulo-2^XLEN (or 2^(2*XLEN)) arithmetic; there is no saturation.

Test Plan:
- XLEN=32, MUL rs1=7, rs2=0xFFFFFFFD → result=0xFFFFFFEB; done high only in the cycle after E33; stall_req high from the start cycle through FIN.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- DIVU 100/7 → 14; REMU → 2; DIV -7/2 → 0xFFFFFFFD; REM → 0xFFFFFFFF.
- DIV 5/0 → 0xFFFFFFFF and REM 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0; done in the cycle after E0 in all four cases.
- flush at iteration 10 → no done, busy=0 next cycle, result unchanged; a new MUL started two cycles later completes correctly. reset mid-CALC → all outputs 0.
- start with funct7=0100000 (SUB) → is_mext=0, stall_req=0, state stays IDLE; start asserted while busy → ignored, the in-flight result is unaffected.
